cpu_clock_ctrl: RTL

- Sequences the 65C02 core clock from the 27 MHz board clock.
- Produces a phi2 level plus one-cycle rise/fall enable strobes from a runtime-loadable half-period divisor.
- Adds run/halt/single-step control for the debug UART monitor and wait-state stretching for slow peripherals.
- Sits between the top level and the CPU core/bus decoder.

---
 rtl/cpu_clk_pkg.sv | 18 +
 rtl/cpu_clock_ctrl_phase_timer.sv | 46 ++++
 rtl/cpu_clock_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the 65C02 clock sequencer: the run/halt/step state
// encoding and the default counter geometry.
package cpu_clk_pkg;

    // Width of the half-period counter and divisor.
    localparam int CPU_CNT_W = 16;

    // Half-period in board-clock cycles after reset (27 MHz -> ~1.04 MHz).
    localparam int CPU_DEFAULT_DIV = 13;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } clk_state_e;

endpackage

// File: rtl/cpu_clock_ctrl_phase_timer.sv
// phase_timer: half-period counter for one phi2 level. Counts 0..div-1; at
// terminal count it wraps to 0 unless hold is set, in which case it parks at
// div-1 (used for wait-state stretching and for halting in the low phase).
module phase_timer
    import cpu_clk_pkg::*;
#(
    parameter int CNT_W = CPU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] div,
    input  logic             hold,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] last_s;
    logic             tc_s;

    // Terminal value of the phase; div is never 0 so div-1 cannot underflow.
    // Using >= keeps the counter self-recovering should it ever pass div-1.
    always_comb begin
        last_s = div - CNT_ONE;
        tc_s   = (cnt_r >= last_s);
    end

    // Count up to terminal count, then wrap to zero or park while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (tc_s) begin
            if (hold) begin
                cnt_r <= last_s;
            end else begin
                cnt_r <= '0;
            end
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign tc = tc_s;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: generates the 65C02 phi2 clock and its rise/fall enable
// strobes from the board clock, with run/halt/single-step control for the
// debug monitor and wait-state stretching of the phi2-high phase.
// Optional feature: define CPU_CLOCK_CTRL_CYCLE_CNT_EN to add a CPU cycle
// counter (cycle_count output, cycle_clr input, CYC_W parameter).
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int CNT_W       = cpu_clk_pkg::CPU_CNT_W,
    parameter int DEFAULT_DIV = cpu_clk_pkg::CPU_DEFAULT_DIV
`ifdef CPU_CLOCK_CTRL_CYCLE_CNT_EN
    ,
    parameter int CYC_W       = 32
`endif
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             wait_req,
`ifdef CPU_CLOCK_CTRL_CYCLE_CNT_EN
    input  logic             cycle_clr,
    output logic [CYC_W-1:0] cycle_count,
`endif
    output logic             phi2,
    output logic             phi2_rise,
    output logic             phi2_fall,
    output logic             running
);

    localparam logic [CNT_W-1:0] DIV_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEFAULT_DIV);

    clk_state_e       state_r;
    clk_state_e       state_next_s;

    logic             halt_pend_r;
    logic             halt_pend_next_s;
    logic             run_pend_r;
    logic             run_pend_next_s;
    logic             step_pending_r;
    logic             step_pending_next_s;

    logic             phi2_r;
    logic             phi2_rise_r;
    logic             phi2_fall_r;
    logic             running_r;

    logic [CNT_W-1:0] div_active_r;
    logic [CNT_W-1:0] div_shadow_r;
    logic [CNT_W-1:0] div_in_eff_s;

    logic             tc_s;
    logic             low_end_ok_s;
    logic             high_end_ok_s;
    logic             hold_s;
    logic             rise_ev_s;
    logic             fall_ev_s;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk  (clk_in),
        .rst  (rst),
        .div  (div_active_r),
        .hold (hold_s),
        .tc   (tc_s)
    );

    // State register plus the request bookkeeping that travels with it.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r        <= ST_RUN;
            halt_pend_r    <= 1'b0;
            run_pend_r     <= 1'b0;
            step_pending_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            halt_pend_r    <= halt_pend_next_s;
            run_pend_r     <= run_pend_next_s;
            step_pending_r <= step_pending_next_s;
        end
    end

    // Next-state logic: halt > step > run; halts only land on a fall boundary
    // or inside the low phase so the high phase is never truncated.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_req && !phi2_r) begin
                    state_next_s = ST_HALT;
                end else if (fall_ev_s && (halt_pend_r || halt_req)) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (halt_req) begin
                    state_next_s = ST_HALT;
                end else if (step_req) begin
                    state_next_s = ST_STEP;
                end else if (run_req) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_STEP: begin
                if (halt_req && !phi2_r) begin
                    state_next_s = ST_HALT;
                end else if (fall_ev_s) begin
                    state_next_s = (!halt_req && (run_pend_r || run_req)) ? ST_RUN : ST_HALT;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase

        // A halt seen during the RUN high phase is remembered until the fall.
        if ((state_r == ST_RUN) && phi2_r && !fall_ev_s) begin
            halt_pend_next_s = halt_pend_r | halt_req;
        end else begin
            halt_pend_next_s = 1'b0;
        end

        // A run seen during a step resumes RUN after the step's fall.
        if ((state_r == ST_STEP) && !fall_ev_s) begin
            if (halt_req) begin
                run_pend_next_s = 1'b0;
            end else if (run_req) begin
                run_pend_next_s = 1'b1;
            end else begin
                run_pend_next_s = run_pend_r;
            end
        end else begin
            run_pend_next_s = 1'b0;
        end

        // The step's rise is owed from entry into STEP until it happens.
        step_pending_next_s = (state_next_s == ST_STEP) && !rise_ev_s;
    end

    // Phase-end permissions and the rise/fall events they produce.
    always_comb begin
        high_end_ok_s = ~wait_req;
        if (halt_req) begin
            low_end_ok_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN:  low_end_ok_s = 1'b1;
                ST_STEP: low_end_ok_s = step_pending_r;
                default: low_end_ok_s = 1'b0;
            endcase
        end

        if (phi2_r) begin
            hold_s = ~high_end_ok_s;
        end else begin
            hold_s = ~low_end_ok_s;
        end

        rise_ev_s    = tc_s & ~phi2_r & low_end_ok_s;
        fall_ev_s    = tc_s &  phi2_r & high_end_ok_s;
        div_in_eff_s = (div_in == '0) ? DIV_ONE : div_in;
    end

    // Registered phi2 level, edge strobes and run indication.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            phi2_r      <= 1'b0;
            phi2_rise_r <= 1'b0;
            phi2_fall_r <= 1'b0;
            running_r   <= 1'b1;
        end else begin
            phi2_r      <= phi2_r ^ (rise_ev_s | fall_ev_s);
            phi2_rise_r <= rise_ev_s;
            phi2_fall_r <= fall_ev_s;
            running_r   <= (state_next_s == ST_RUN);
        end
    end

    // Shadow divisor takes loads at any time; the active copy only changes on
    // the fall edge so neither phase is ever built from two divisors.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_shadow_r <= DIV_RESET;
            div_active_r <= DIV_RESET;
        end else begin
            if (div_load) begin
                div_shadow_r <= div_in_eff_s;
            end else begin
                div_shadow_r <= div_shadow_r;
            end
            if (fall_ev_s) begin
                div_active_r <= div_shadow_r;
            end else begin
                div_active_r <= div_active_r;
            end
        end
    end

`ifdef CPU_CLOCK_CTRL_CYCLE_CNT_EN
    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    logic [CYC_W-1:0] cycle_count_r;

    // CPU cycle counter: one count per phi2 fall, clear has priority.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cycle_count_r <= '0;
        end else if (cycle_clr) begin
            cycle_count_r <= '0;
        end else if (fall_ev_s) begin
            cycle_count_r <= cycle_count_r + CYC_ONE;
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    assign cycle_count = cycle_count_r;
`endif

    assign phi2      = phi2_r;
    assign phi2_rise = phi2_rise_r;
    assign phi2_fall = phi2_fall_r;
    assign running   = running_r;

endmodule
